riscv_mmio_uart_tx: RTL and testbench
=====================================

Name: riscv_mmio_uart_tx

Overview:
- Memory-mapped responder on the CPU data-memory port (addr / wr_en / byte_sel / wr_data / rd_data). It consumes CPU stores and serialises them as 8N1 UART frames.
- Sits beside riscv_dmem in the top level. The top decodes o_sel to steer read data back to the CPU.
- Read data is combinational, so single-cycle loads work unchanged. Stores commit on the rising clock edge, the same as dmem.

Parameters:
- XLEN, 32, bus data/address width
- BASE_ADDR, 32'h0000_1000, byte address of register block (16-byte aligned)
- CLKS_PER_BIT, 868, clocks per UART bit (100 MHz / 115200)
- FIFO_DEPTH, 8, TX FIFO entries (power of 2, >=2)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high
- i_addr  in  XLEN  byte address from CPU
- i_wr_en  in  1  store strobe
- i_byte_sel  in  4  byte-lane enables
- i_wr_data  in  XLEN  store data
- o_rd_data  out  XLEN  combinational register read data
- o_sel  out  1  address hit: i_addr[XLEN-1:4]==BASE_ADDR[XLEN-1:4]
- o_txd  out  1  serial output, idle high
- o_busy  out  1  frame in progress or FIFO non-empty
- o_irq  out  1  CTRL.irq_en & FIFO empty & FSM IDLE

Behaviour:
- Register map (offset = i_addr[3:2]):
  - 0 TXDATA: write with byte_sel[0]=1 pushes wr_data[7:0]. Reads 0.
  - 1 STATUS (read): [0] fsm_active, [1] full, [2] empty, [3] overflow (sticky), [15:8] fifo count. Writing 1 to bit3 with byte_sel[0] clears overflow.
  - 2 CTRL (R/W, byte_sel[0]): [0] tx_en, [1] irq_en.
  - 3: reserved, reads 0, writes ignored.
- o_rd_data = 0 when o_sel=0. Reads have no side effects.
- Writes only when i_wr_en & o_sel; other byte lanes are ignored.
- Reset values:
  - o_txd=1, FIFO empty, overflow=0, tx_en=0, irq_en=0, FSM=IDLE, counters 0.
  - Outputs: o_busy=0, o_irq=0.
- Async reset mid-frame: o_txd returns to 1 immediately and the frame is abandoned.
- FIFO:
  - Circular, wr/rd pointers with one extra wrap bit. Count = wr-rd.
  - Push to a full FIFO is dropped and sets overflow in the same edge.
  - Push and pop in the same cycle when full: the push is accepted and count is unchanged.
  - Push and pop in the same cycle when empty cannot occur, because pop requires non-empty.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if tx_en & !empty, pop the head into shift reg, go to START, clear baud count. o_txd=1.
  - START: o_txd=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: o_txd=shift[0] (LSB first) for CLKS_PER_BIT cycles per bit. After bit_idx=7 go to STOP.
  - STOP: o_txd=1 for CLKS_PER_BIT cycles, then IDLE.
- Back-to-back frames: IDLE spends exactly 1 cycle between frames, so each frame period is 10*CLKS_PER_BIT+1 cycles.
- Latency: a store at edge N into an empty FIFO with tx_en=1 → START entered at edge N+1, o_txd falls after N+1.
- Clearing tx_en mid-frame completes the current frame; no further pops follow.
- Writing TXDATA while tx_en=0 queues the byte.
- Baud counter width is $clog2(CLKS_PER_BIT). It wraps at CLKS_PER_BIT-1.

Decomposition:
- Shared package riscv_configs additions:
  - UART register offset constants (TXDATA/STATUS/CTRL)
  - STATUS/CTRL bit-position defines
  - FSM state encodings (2-bit)
- One natural sub-module: riscv_sync_fifo, a parameterised width/depth synchronous FIFO with push/pop/full/empty/count, reusable for a later RX path.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 in bench):
- Reset, then read STATUS (addr 0x1004) → o_rd_data=0x0000_0004 and o_txd=1. o_sel=0 and rd_data=0 at addr 0x2000.
- Write CTRL=1, then TXDATA=0xA5 → after 1 cycle o_txd low for 4 cycles. Bits 1,0,1,0,0,1,0,1 follow, 4 cycles each, then stop high. Frame is 40 cycles and o_busy falls after it.
- tx_en=0, push 5 bytes 0x11..0x15 → STATUS count=4, full=1, overflow=1. Write 0x8 to STATUS clears overflow. Set tx_en → 0x11..0x14 transmitted, 41-cycle spacing.
- Store with byte_sel=4'b0010 to TXDATA → no push, count unchanged.
- Assert i_rst mid-DATA of a 0xFF frame → o_txd=1 same cycle, STATUS=0x4 afterward, no residual frame after release.
- irq_en=1, tx_en=1, one byte sent → o_irq=0 during frame, 1 in the cycle after STOP completes.

Source files
------------

// File: rtl/riscv_mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions and the 2-bit TX state encoding.
package riscv_mmio_uart_tx_pkg;

  localparam logic [1:0] UART_OFF_TXDATA = 2'd0;
  localparam logic [1:0] UART_OFF_STATUS = 2'd1;
  localparam logic [1:0] UART_OFF_CTRL   = 2'd2;
  localparam logic [1:0] UART_OFF_RSVD   = 2'd3;

  localparam int unsigned STAT_ACTIVE_BIT = 0;
  localparam int unsigned STAT_FULL_BIT   = 1;
  localparam int unsigned STAT_EMPTY_BIT  = 2;
  localparam int unsigned STAT_OVF_BIT    = 3;
  localparam int unsigned STAT_CNT_LSB    = 8;
  localparam int unsigned STAT_CNT_W      = 8;

  localparam int unsigned CTRL_TXEN_BIT  = 0;
  localparam int unsigned CTRL_IRQEN_BIT = 1;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Assemble the 32-bit STATUS word from its fields.
  function automatic logic [31:0] pack_status(input logic active, input logic full,
                                               input logic empty, input logic ovf,
                                               input logic [STAT_CNT_W-1:0] count);
    logic [31:0] w;
    w = '0;
    w[STAT_ACTIVE_BIT] = active;
    w[STAT_FULL_BIT]   = full;
    w[STAT_EMPTY_BIT]  = empty;
    w[STAT_OVF_BIT]    = ovf;
    w[STAT_CNT_LSB +: STAT_CNT_W] = count;
    return w;
  endfunction

endpackage

// File: rtl/riscv_mmio_uart_tx_fifo.sv
// Parameterised synchronous FIFO with wrap-bit pointers; a push is accepted
// when full only if a pop happens in the same cycle.
module riscv_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign o_empty = (wr_q == rd_q);
  assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign o_count = wr_q - rd_q;
  assign o_data  = mem_q[rd_q[AW-1:0]];

  assign pop_ok  = i_pop & ~o_empty;
  assign push_ok = i_push & (~o_full | pop_ok);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + (AW+1)'(1);
    if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage carries no reset; contents are only visible through valid pointers.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/riscv_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data port: stores to TXDATA
// queue bytes into a FIFO that a four-state serialiser drains.
module riscv_mmio_uart_tx
  import riscv_mmio_uart_tx_pkg::*;
#(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned      CLKS_PER_BIT = 868,
  parameter int unsigned      FIFO_DEPTH   = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_addr,
  input  logic            i_wr_en,
  input  logic [3:0]      i_byte_sel,
  input  logic [XLEN-1:0] i_wr_data,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_sel,
  output logic            o_txd,
  output logic            o_busy,
  output logic            o_irq
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             irq_q, irq_d;
  logic             tx_en_q, tx_en_d;
  logic             irq_en_q, irq_en_d;
  logic             ovf_q, ovf_d;

  logic [1:0]       offset;
  logic             wr_hit;
  logic             push;
  logic             pop;
  logic             push_ok;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic [FCW-1:0]   count_d;
  logic [7:0]       fifo_head;
  logic             baud_done;
  logic             unused_bits;

  assign offset  = i_addr[3:2];
  assign o_sel   = (i_addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
  assign wr_hit  = i_wr_en & o_sel & i_byte_sel[0];
  assign push    = wr_hit & (offset == UART_OFF_TXDATA);
  assign push_ok = push & (~fifo_full | pop);
  assign count_d = fifo_count + FCW'(push_ok) - FCW'(pop);

  assign unused_bits = ^{i_addr[1:0], i_byte_sel[3:1], i_wr_data[XLEN-1:8]};

  riscv_sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  (i_wr_data[7:0]),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // Combinational register read port; unmapped addresses return zero.
  always_comb begin
    o_rd_data = '0;
    if (o_sel) begin
      case (offset)
        UART_OFF_STATUS: o_rd_data = XLEN'(pack_status(state_q != TX_IDLE, fifo_full,
                                                       fifo_empty, ovf_q,
                                                       STAT_CNT_W'(fifo_count)));
        UART_OFF_CTRL: begin
          o_rd_data[CTRL_TXEN_BIT]  = tx_en_q;
          o_rd_data[CTRL_IRQEN_BIT] = irq_en_q;
        end
        default: o_rd_data = '0;
      endcase
    end
  end

  // Control and sticky overflow; a dropped push is one that finds the FIFO full with no pop.
  always_comb begin
    tx_en_d  = tx_en_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    if (wr_hit && offset == UART_OFF_CTRL) begin
      tx_en_d  = i_wr_data[CTRL_TXEN_BIT];
      irq_en_d = i_wr_data[CTRL_IRQEN_BIT];
    end
    if (push && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end else if (wr_hit && offset == UART_OFF_STATUS && i_wr_data[STAT_OVF_BIT]) begin
      ovf_d = 1'b0;
    end
  end

  assign baud_done = (baud_q == BAUD_LAST);

  // Serialiser next-state; o_txd is registered from the next state so it
  // changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    txd_d   = 1'b1;
    case (state_q)
      TX_IDLE: begin
        if (tx_en_q && !fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          baud_d  = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = TX_IDLE;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
    case (state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
    busy_d = (state_d != TX_IDLE) | (count_d != '0);
    irq_d  = irq_en_d & (count_d == '0) & (state_d == TX_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= TX_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      irq_q    <= 1'b0;
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      irq_q    <= irq_d;
      tx_en_q  <= tx_en_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_txd  = txd_q;
  assign o_busy = busy_q;
  assign o_irq  = irq_q;

endmodule

// File: tb/tb_riscv_mmio_uart_tx.sv
// Directed bench for riscv_mmio_uart_tx with CLKS_PER_BIT=4 and a 4-entry FIFO.
module tb_riscv_mmio_uart_tx;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        wr_en;
  logic [3:0]  byte_sel;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        sel;
  logic        txd;
  logic        busy;
  logic        irq;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  riscv_mmio_uart_tx #(
    .XLEN         (32),
    .BASE_ADDR    (32'h0000_1000),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_addr     (addr),
    .i_wr_en    (wr_en),
    .i_byte_sel (byte_sel),
    .i_wr_data  (wr_data),
    .o_rd_data  (rd_data),
    .o_sel      (sel),
    .o_txd      (txd),
    .o_busy     (busy),
    .o_irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One store; returns at the falling edge after the committing rising edge.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr = a; wr_data = d; byte_sel = be; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; byte_sel = 4'h0; wr_data = '0; addr = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rd_data;
    addr = '0;
  endtask

  // Samples 40 frame cycles plus the following idle cycle.
  task automatic expect_frame(input logic [7:0] b);
    logic e;
    for (int k = 0; k < 41; k++) begin
      @(negedge clk);
      if (k < 4)       e = 1'b0;
      else if (k < 36) e = b[3'((k - 4) / 4)];
      else             e = 1'b1;
      chk($sformatf("txd_%02h_c%0d", b, k), 32'(txd), 32'(e));
      if (k < 40) chk($sformatf("irq_low_%02h_c%0d", b, k), 32'(irq), 32'h0);
      if (k == 20) chk($sformatf("busy_mid_%02h", b), 32'(busy), 32'h1);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic        saw_low;
    rst = 1'b1; addr = '0; wr_en = 1'b0; byte_sel = 4'h0; wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and address decode
    bus_rd(32'h1004, r);  chk("status_reset", r, 32'h0000_0004);
    chk("txd_reset", 32'(txd), 32'h1);
    chk("busy_reset", 32'(busy), 32'h0);
    chk("irq_reset", 32'(irq), 32'h0);
    bus_rd(32'h1008, r);  chk("ctrl_reset", r, 32'h0);
    addr = 32'h2000; #1;
    chk("sel_miss", 32'(sel), 32'h0);
    chk("rd_miss", rd_data, 32'h0);
    addr = 32'h100C; #1;
    chk("sel_hit", 32'(sel), 32'h1);
    chk("rd_rsvd", rd_data, 32'h0);
    addr = '0;

    // Single frame of 0xA5
    bus_wr(32'h1008, 32'h1, 4'h1);
    bus_rd(32'h1008, r);  chk("ctrl_txen", r, 32'h1);
    bus_wr(32'h1000, 32'hA5, 4'h1);
    chk("txd_before_start", 32'(txd), 32'h1);
    chk("busy_queued", 32'(busy), 32'h1);
    expect_frame(8'hA5);
    chk("busy_after_a5", 32'(busy), 32'h0);
    bus_rd(32'h1000, r);  chk("txdata_reads0", r, 32'h0);

    // Wrong byte lane on TXDATA must not push
    bus_wr(32'h1000, 32'h77, 4'b0010);
    bus_rd(32'h1004, r);  chk("bytesel_nopush", r, 32'h0000_0004);
    chk("txd_no_frame", 32'(txd), 32'h1);

    // Queue with tx disabled, overflow, clear, then drain
    bus_wr(32'h1008, 32'h0, 4'h1);
    for (int i = 0; i < 5; i++) bus_wr(32'h1000, 32'h11 + 32'(i), 4'h1);
    bus_rd(32'h1004, r);  chk("status_full_ovf", r, 32'h0000_040A);
    chk("busy_queued_disabled", 32'(busy), 32'h1);
    bus_wr(32'h1004, 32'h8, 4'h1);
    bus_rd(32'h1004, r);  chk("status_ovf_clr", r, 32'h0000_0402);
    bus_wr(32'h1008, 32'h1, 4'h1);
    for (int i = 0; i < 4; i++) expect_frame(8'h11 + 8'(i));
    chk("busy_after_drain", 32'(busy), 32'h0);
    bus_rd(32'h1004, r);  chk("status_drained", r, 32'h0000_0004);

    // Async reset mid-DATA of 0xFF
    bus_wr(32'h1000, 32'hFF, 4'h1);
    repeat (10) @(negedge clk);
    bus_rd(32'h1004, r);  chk("active_mid_ff", r, 32'h0000_0005);
    #1 rst = 1'b1;
    #1;
    chk("txd_rst_data", 32'(txd), 32'h1);
    chk("busy_rst_data", 32'(busy), 32'h0);
    bus_rd(32'h1004, r);  chk("status_in_rst", r, 32'h0000_0004);
    @(negedge clk);
    rst = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
    end
    chk("no_residual_frame", 32'(saw_low), 32'h0);
    bus_rd(32'h1008, r);  chk("ctrl_after_rst", r, 32'h0);

    // Async reset while the start bit is driving low
    bus_wr(32'h1008, 32'h1, 4'h1);
    bus_wr(32'h1000, 32'h00, 4'h1);
    @(negedge clk);
    chk("txd_start_low", 32'(txd), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("txd_rst_start", 32'(txd), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_rd(32'h1004, r);  chk("status_after_rst2", r, 32'h0000_0004);

    // Interrupt after a frame completes
    bus_wr(32'h1008, 32'h3, 4'h1);
    chk("irq_idle_empty", 32'(irq), 32'h1);
    bus_wr(32'h1000, 32'h5A, 4'h1);
    chk("irq_after_push", 32'(irq), 32'h0);
    expect_frame(8'h5A);
    chk("irq_after_stop", 32'(irq), 32'h1);
    chk("busy_after_5a", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
